// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_arbiter
//  Purpose  : Round-robin arbiter and IDLE/ACCESS/DONE sequencer sharing one
//             single-port 64-bit data memory between the core load/store
//             unit (requester 0) and the loader/DMA port (requester 1).
//  Options  : DMARB_ALIGN_CHECK_EN - reject doubleword-misaligned accesses
//             (no memory strobe, ack with err = 1, rdata forced to 0).
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic              last_q,      last_d;      // most recently served requester
    logic              owner_q,     owner_d;     // requester of the access in flight
    logic              we_q,        we_d;
    logic              bad_q,       bad_d;       // access rejected for misalignment
    logic              ack0_q,      ack0_d;
    logic              ack1_q,      ack1_d;
    logic              err_q,       err_d;
    logic              busy_q,      busy_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;  // doubles as the latched address
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d; // doubles as the latched write data
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q,  mem_read_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;

    logic              win_sel;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_bad;

    // Winner selection: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        win_sel = 1'b0;
        if (req0 && req1) begin
            win_sel = ~last_q;
        end else if (req1) begin
            win_sel = 1'b1;
        end
        win_we    = win_sel ? we1    : we0;
        win_addr  = win_sel ? addr1  : addr0;
        win_wdata = win_sel ? wdata1 : wdata0;
`ifdef DMARB_ALIGN_CHECK_EN
        win_bad   = (win_addr[2:0] != 3'b000);
`else
        win_bad   = 1'b0;
`endif
    end

    // Next-state and next-output logic for the three-state access sequence.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        we_d        = we_q;
        bad_d       = bad_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        err_d       = 1'b0;
        busy_d      = busy_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
        rdata_d     = rdata_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (req0 || req1) begin
                    state_d     = S_ACCESS;
                    last_d      = win_sel;
                    owner_d     = win_sel;
                    we_d        = win_we;
                    bad_d       = win_bad;
                    busy_d      = 1'b1;
                    mem_addr_d  = win_addr;
                    mem_wdata_d = win_wdata;
                    // Strobes are registered so they are clean for the whole ACCESS cycle.
                    mem_write_d = win_we  & ~win_bad;
                    mem_read_d  = ~win_we & ~win_bad;
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                ack0_d  = ~owner_q;
                ack1_d  = owner_q;
                err_d   = bad_q;
                if (bad_q) begin
                    rdata_d = '0;
                end else if (!we_q) begin
                    rdata_d = mem_rdata;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops every strobe immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            bad_q       <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            bad_q       <= bad_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            rdata_q     <= rdata_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_write = mem_write_q;
    assign mem_read  = mem_read_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_arbiter
//  Purpose  : Scoreboard bench for data_mem_arbiter with a behavioural
//             single-port memory (combinational read, write on clock edge).
//  Options  : DMARB_ALIGN_CHECK_EN selects the misaligned-access expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [63:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err, busy, mem_write, mem_read;
    logic [63:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic [63:0] mem [0:31];

    int pass_cnt  = 0;
    int check_cnt = 0;

    typedef struct {
        int          id;
        logic        err;
        logic        chk_rd;
        logic [63:0] rd;
        int          strobes;
        logic [63:0] addr;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    // Behavioural data memory, doubleword indexed.
    assign mem_rdata = mem[mem_addr[7:3]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:3]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: counts strobe cycles per access and scores each ack against the queue.
    int          strobe_cnt = 0;
    logic [63:0] seen_addr  = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            strobe_cnt = 0;
        end else begin
            if (mem_read || mem_write) begin
                strobe_cnt++;
                seen_addr = mem_addr;
                chk("strobe_exclusive", {63'd0, mem_read & mem_write}, 64'd0);
            end
            if (ack0 || ack1) begin
                chk("single_ack", {63'd0, ack0 & ack1}, 64'd0);
                if (sbq.size() == 0) begin
                    chk("unexpected_ack", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("ack_owner", {63'd0, ack1}, 64'(e.id));
                    chk("err", {63'd0, err}, {63'd0, e.err});
                    chk("strobe_cycles", 64'(strobe_cnt), 64'(e.strobes));
                    if (e.chk_rd)      chk("rdata", rdata, e.rd);
                    if (e.strobes > 0) chk("mem_addr", seen_addr, e.addr);
                end
                strobe_cnt = 0;
            end
        end
    end

    task automatic drive(input int id, input logic r, input logic w,
                         input logic [63:0] a, input logic [63:0] d);
        if (id == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else         begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic push(input int id, input logic e_err, input logic chk_rd,
                        input logic [63:0] rd, input int strobes, input logic [63:0] a);
        exp_t e;
        e.id = id; e.err = e_err; e.chk_rd = chk_rd; e.rd = rd;
        e.strobes = strobes; e.addr = a;
        sbq.push_back(e);
    endtask

    // One access from an idle arbiter; checks the 2-cycle sample-to-ack latency.
    task automatic do_access(input int id, input logic w, input logic [63:0] a,
                             input logic [63:0] d, input logic chk_rd,
                             input logic [63:0] rd, input logic e_err, input int strobes);
        int n;
        bit got;
        push(id, e_err, chk_rd, rd, strobes, a);
        @(posedge clk); #1;
        drive(id, 1'b1, w, a, d);
        n = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            n++;
            if ((id == 0) ? ack0 : ack1) got = 1;
        end
        chk("ack_latency", 64'(n - 1), 64'd2);
        @(posedge clk); #1;
        drive(id, 1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    initial begin
        int acks;
        bit got;
        for (int i = 0; i < 32; i++) mem[i] = '0;

        // Reset with random inputs: every output must be zero.
        req0 = 1'($urandom); req1 = 1'($urandom); we0 = 1'($urandom); we1 = 1'($urandom);
        addr0 = {$urandom, $urandom}; addr1 = {$urandom, $urandom};
        wdata0 = {$urandom, $urandom}; wdata1 = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        chk("rst_ack0", {63'd0, ack0}, 64'd0);
        chk("rst_ack1", {63'd0, ack1}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_strobes", {62'd0, mem_write, mem_read}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
        reset = 1'b1;

        // First read, then write/read of a known pattern on requester 0.
        do_access(0, 1'b0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b0, 1);
        do_access(0, 1'b1, 64'd8, 64'hDEADBEEF_CAFEF00D, 1'b0, 64'd0, 1'b0, 1);
        do_access(0, 1'b0, 64'd8, 64'd0, 1'b1, 64'hDEADBEEF_CAFEF00D, 1'b0, 1);

        // Read-data hold across a later write.
        do_access(1, 1'b1, 64'd16, 64'h1, 1'b0, 64'd0, 1'b0, 1);
        do_access(0, 1'b0, 64'd16, 64'd0, 1'b1, 64'h1, 1'b0, 1);
        do_access(0, 1'b1, 64'd0, 64'h5, 1'b1, 64'h1, 1'b0, 1);
        // Requester 1 served last, so a tie next goes to requester 0.
        do_access(1, 1'b0, 64'd16, 64'd0, 1'b1, 64'h1, 1'b0, 1);

        // Both requesting continuously: grants 0,1,0,1 with addresses 0,16.
        push(0, 1'b0, 1'b1, 64'h5, 1, 64'd0);
        push(1, 1'b0, 1'b1, 64'h1, 1, 64'd16);
        push(0, 1'b0, 1'b1, 64'h5, 1, 64'd0);
        push(1, 1'b0, 1'b1, 64'h1, 1, 64'd16);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 64'd0, 64'd0);
        drive(1, 1'b1, 1'b0, 64'd16, 64'd0);
        acks = 0;
        for (int i = 0; i < 40 && acks < 4; i++) begin
            @(negedge clk);
            if (ack0 || ack1) acks++;
        end
        chk("rr_ack_count", 64'(acks), 64'd4);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 64'd0);

        // Misaligned read at address 12.
`ifdef DMARB_ALIGN_CHECK_EN
        do_access(1, 1'b0, 64'd12, 64'd0, 1'b1, 64'd0, 1'b1, 0);
`else
        do_access(1, 1'b0, 64'd12, 64'd0, 1'b1, 64'hDEADBEEF_CAFEF00D, 1'b0, 1);
`endif

        // Reset during ACCESS of a write to address 24.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 64'd24, 64'h77);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (mem_write) got = 1;
        end
        chk("mid_rst_reach_access", {63'd0, got}, 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_strobes", {62'd0, mem_write, mem_read}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_no_ack", {62'd0, ack0, ack1}, 64'd0);
        end
        chk("mid_rst_no_commit", mem[3], 64'd0);
        push(0, 1'b0, 1'b0, 64'd0, 1, 64'd24);
        reset = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ack0) got = 1;
        end
        chk("mid_rst_restart_ack", {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (2) @(negedge clk);
        chk("mid_rst_commit_after", mem[3], 64'h77);
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and sequencer for the single-port 64-bit data memory. It shares the memory's address, write-data and read/write strobes between requester 0 (core load/store unit) and requester 1 (loader/DMA port). Arbitration is round-robin, and each access runs through a fixed three-state sequence. The block sits between the requesters and the data memory and owns every memory strobe.

## Interface
Parameters:
- ADDR_W, 64, address width (byte address)
- DATA_W, 64, data width (one doubleword)

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- req0 / req1  input  1  access request, requester 0 / 1
- we0 / we1  input  1  1 = write, 0 = read
- addr0 / addr1  input  ADDR_W  byte address
- wdata0 / wdata1  input  DATA_W  write data
- ack0 / ack1  output  1  one-cycle completion pulse
- err  output  1  misaligned-access flag, valid with ack
- rdata  output  DATA_W  read data, valid with ack of a read
- busy  output  1  high in ACCESS and DONE
- mem_addr  output  ADDR_W  to data memory Mem_Addr
- mem_wdata  output  DATA_W  to data memory Write_Data
- mem_write  output  1  to data memory MemWrite
- mem_read  output  1  to data memory MemRead
- mem_rdata  input  DATA_W  from data memory Read_Data (combinational read)

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE.
- IDLE:
  - If any req is high, choose a winner.
  - Latch owner, we, addr and wdata of the winner.
  - Go to ACCESS. Otherwise stay in IDLE.
- Round-robin:
  - Register `last` holds the most recently served requester; reset value 1.
  - A single requester always wins.
  - If both request, the winner is the requester that is not `last`.
  - `last` is updated on the IDLE→ACCESS transition.
- ACCESS (exactly 1 cycle):
  - mem_addr and mem_wdata carry the latched values.
  - mem_write = latched we; mem_read = !latched we.
  - The memory write commits on the closing edge.
  - On a read, mem_rdata is captured into rdata on the closing edge.
  - Go to DONE.
- DONE (exactly 1 cycle):
  - ack of the owner is high; err is valid.
  - Strobes are low.
  - Go to IDLE.
- Requester rules:
  - Hold req, we, addr and wdata stable from assertion until ack is seen.
  - Drop req on the edge that ends the ack cycle. A req still high in the following IDLE is a new request.
- rdata holds its value until the next read capture. Writes leave rdata unchanged.
- Reset values: ack0 = ack1 = err = busy = 0; mem_write = mem_read = 0; mem_addr = mem_wdata = rdata = 0; `last` = 1; owner = 0.
- Reset asserted mid-operation:
  - Immediate return to IDLE; strobes drop asynchronously.
  - An in-flight write commits only if the ACCESS edge has already occurred.
  - The request is lost, not acked, and re-arbitrated after reset is released.

## Timing
- A request seen in IDLE at edge N produces ACCESS in cycle N+1 and ack in cycle N+2.
- Latency is 2 cycles from the sampling edge to the ack-high cycle.
- Throughput: at most one access per 3 cycles (IDLE, ACCESS, DONE).
- Back-to-back with both requesting continuously, grants alternate 0, 1, 0, 1, ...
- A request arriving during ACCESS or DONE waits for the next IDLE.
- mem_write is high for exactly one cycle per write and never asserted together with mem_read.

## Configuration
- DMARB_ALIGN_CHECK_EN defined:
  - In IDLE, a winner with latched addr[2:0] != 0 takes ACCESS with both strobes low and no memory access.
  - DONE then asserts ack with err = 1; rdata is forced to 0.
- Not defined:
  - Alignment is not checked; the address is passed to memory unchanged.
  - err is tied to 0.

## Test plan
- Reset: reset = 0 with random inputs → all outputs 0, FSM IDLE. Release reset; req0 with we0 = 0, addr0 = 0 → ack0 two cycles after the sampling edge, mem_read high for exactly one cycle.
- Write then read on requester 0: write wdata0 = 64'hDEADBEEF_CAFEF00D to addr 8, then read addr 8 → rdata = 64'hDEADBEEF_CAFEF00D with ack0, err = 0.
- Simultaneous requests: req0 and req1 held high for 4 transactions (addr0 = 0, addr1 = 16) → ack order 0, 1, 0, 1; mem_addr alternates 0, 16.
- Read-data hold: requester 1 writes 64'h1 at addr 16, then requester 0 reads addr 16 → rdata = 1 on ack0. A following write leaves rdata unchanged.
- Misaligned access with DMARB_ALIGN_CHECK_EN defined: req1 read at addr 12 → mem_read and mem_write stay 0, ack1 high with err = 1, rdata = 0. Without the macro: memory is read at address 12 and err = 0.
- Reset mid-access: assert reset during ACCESS of a write to addr 24 → strobes low immediately and no ack. After release with req held, the access restarts and completes with ack.
